tcp_rx_fetch: RTL and testbench
===============================

# tcp_rx_fetch

Receive-side session fetcher between the TCP offload engine's notification/read interface and the SNIC handler's rx ports. It accepts a "data available" notification, issues the matching read-package request, checks the returned metadata, and forwards one tagged message (meta word plus data beats) downstream. It handles one message at a time and keeps sticky error flags and a message counter for debug.

## Interface
- TIMEOUT_CYCLES, 4096: maximum cycles spent waiting for rx metadata after a request is issued (range 2..65535).
- net_clk  in  1  clock for all logic.
- net_areset  in  1  asynchronous reset, active-high.
- s_axis_notifications_valid/ready/data  in/out/in  1/1/88  data layout: [15:0] session, [31:16] length in bytes, [63:32] IP, [79:64] port, [80] closed, rest reserved.
- m_axis_read_package_valid/ready/data  out/in/out  1/1/32  data layout: [15:0] session, [31:16] length.
- s_axis_rx_metadata_valid/ready/data  in/out/in  1/1/16  data is the session.
- s_axis_rx_data_valid/ready/data/keep/last  in/out/in/in/in  1/1/64/8/1  payload from the TOE.
- m_axis_msg_meta_valid/ready/data  out/in/out  1/1/32  data layout: [15:0] session, [31:16] length.
- m_axis_msg_data_valid/ready/data/keep/last  out/in/out/out/out  1/1/64/8/1  payload to the consumer.
- err_len  out  1  sticky: the byte count at last beat did not equal the requested length.
- err_session  out  1  sticky: the metadata session did not equal the requested session.
- err_timeout  out  1  sticky: the metadata wait expired.
- msg_count  out  32  count of completed messages; wraps at 2^32.

## Operation
- The FSM has five states:
  - IDLE → REQ on notification accept, when length ≠ 0.
  - REQ → META on read_package accept.
  - META → MOUT on metadata accept.
  - META → IDLE on timeout.
  - MOUT → DATA on msg_meta accept.
  - DATA → IDLE on accept of the beat with last.
- s_axis_notifications_ready = 1 only in IDLE.
- A notification with length = 0 (closed or not) is accepted and dropped. The FSM stays in IDLE.
- On accept, session and length are latched into registers. read_package data is {length, session}.
- s_axis_rx_metadata_ready = 1 only in META.
  - If the metadata session ≠ the latched session, err_session is set. The flow continues using the latched session.
- m_axis_msg_meta data is {latched length, latched session}, held stable until accepted.
- Data path in DATA state is a pass-through:
  - m_axis_msg_data_valid = s_axis_rx_data_valid.
  - s_axis_rx_data_ready = m_axis_msg_data_ready.
  - data, keep and last are wired straight through.
  - Outside DATA, both valid and ready are 0.
- Byte counter (17 bits):
  - Cleared on entry to DATA.
  - On each accepted beat it adds popcount(keep) (0..8).
  - keep must be LSB-contiguous; this is not checked.
- On the last beat, if counter + popcount(keep) ≠ latched length, err_len is set.
- msg_count increments on every DATA → IDLE transition, including messages with errors.
- Timeout counter (16 bits):
  - Cleared on entry to META and increments each cycle in META.
  - When it reaches TIMEOUT_CYCLES-1 with no metadata accept, err_timeout is set and the FSM returns to IDLE.
  - Metadata accept and timeout in the same cycle: accept wins.
- Stray rx_data beats outside DATA are back-pressured (ready = 0), never dropped.

## Timing
- Reset values:
  - state = IDLE.
  - All output valid signals = 0.
  - read_package data = 0 and msg_meta data = 0.
  - err_len, err_session and err_timeout = 0.
  - msg_count = 0.
  - Counters = 0.
- Reset mid-message aborts with no output. Payload still in flight afterwards stalls until a new DATA state is entered.
- read_package_valid and msg_meta_valid are registered:
  - read_package_valid rises the cycle after the notification accept.
  - msg_meta_valid rises the cycle after the metadata accept.
- Each valid is held until its ready. Data does not change while valid && !ready.
- In DATA, payload latency is zero cycles (combinational). Handshakes follow AXI-Stream rules.
- Minimum message turnaround is 6 cycles with all readys high and a 1-beat payload:
  - notification accept (N).
  - read_package valid (N+1).
  - metadata accept (N+2 at earliest).
  - msg_meta valid (N+3).
  - data beat (N+4).
  - notification_ready high again (N+5).
- Flags are set the cycle after the detecting event and only clear on reset.

## Test plan
- Notification session=0x0012, len=20 with all readys high:
  - read_package data = 0x00140012.
  - Feed metadata 0x0012, then beats with keep FF, FF, 0F (last).
  - Required: msg_meta = 0x00140012, three beats pass unchanged, msg_count=1, no error flags.
- Notification len=0, closed=1:
  - Required: accepted, no read_package, state stays IDLE, msg_count=0.
- Metadata session 0x0013 against requested 0x0012:
  - Required: err_session=1 and msg_meta carries session 0x0012.
- TIMEOUT_CYCLES=16 and metadata withheld:
  - Required: err_timeout rises exactly 16 cycles after META entry, then notification_ready returns to 1.
- len=16 request answered with a single beat keep=FF, last=1:
  - Required: err_len=1 and msg_count=1.
  - Also hold m_axis_msg_data_ready=0 for 5 cycles mid-message: s_axis_rx_data_ready=0 throughout and no beat is lost.
- Assert net_areset while in DATA:
  - Required: every valid = 0, all flags = 0, msg_count=0 during reset.
  - A subsequent normal message completes correctly.

Source files
------------

// File: rtl/tcp_rx_fetch_if.sv
// tcp_rx_fetch_if: AXI-Stream style handshake bundle shared by all tcp_rx_fetch streams
interface tcp_rx_fetch_if #(parameter int DW = 64) ();
  logic valid;
  logic ready;
  logic [DW-1:0] data;
  logic [DW/8-1:0] keep;
  logic last;
  modport master (output valid, data, keep, last, input ready);
  modport slave (input valid, data, keep, last, output ready);
endinterface

// File: rtl/tcp_rx_fetch.sv
// tcp_rx_fetch: turns a TOE data-available notification into one tagged rx message
module tcp_rx_fetch #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic net_clk,
  input logic net_areset,
  tcp_rx_fetch_if.slave s_axis_notifications,
  tcp_rx_fetch_if.master m_axis_read_package,
  tcp_rx_fetch_if.slave s_axis_rx_metadata,
  tcp_rx_fetch_if.slave s_axis_rx_data,
  tcp_rx_fetch_if.master m_axis_msg_meta,
  tcp_rx_fetch_if.master m_axis_msg_data,
  output logic err_len,
  output logic err_session,
  output logic err_timeout,
  output logic [31:0] msg_count
);
  typedef enum logic [2:0] {IDLE, REQ, META, MOUT, DATA} state_t;
  state_t state, state_nx;
  logic [15:0] sess, len, tcnt;
  logic [16:0] bcnt;
  logic [3:0] pop;
  logic n_acc, m_acc, beat, tmo;
  logic unused;
  assign unused = ^{s_axis_notifications.data[87:32], s_axis_notifications.keep,
                    s_axis_notifications.last, s_axis_rx_metadata.keep, s_axis_rx_metadata.last};
  assign n_acc = s_axis_notifications.valid & s_axis_notifications.ready;
  assign m_acc = s_axis_rx_metadata.valid & s_axis_rx_metadata.ready;
  assign beat = s_axis_rx_data.valid & s_axis_rx_data.ready;
  assign tmo = tcnt == 16'(TIMEOUT_CYCLES - 1);
  // state register
  always_ff @(posedge net_clk or posedge net_areset) begin
    if (net_areset) state <= IDLE;
    else state <= state_nx;
  end
  // next-state logic; zero-length notifications are swallowed in IDLE
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (n_acc && s_axis_notifications.data[31:16] != 16'd0) state_nx = REQ;
      REQ: if (m_axis_read_package.ready) state_nx = META;
      META: state_nx = m_acc ? MOUT : (tmo ? IDLE : META);
      MOUT: if (m_axis_msg_meta.ready) state_nx = DATA;
      DATA: if (beat && s_axis_rx_data.last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // outputs decoded from the registered state; payload is a gated pass-through in DATA
  always_comb begin
    s_axis_notifications.ready = state == IDLE;
    m_axis_read_package.valid = state == REQ;
    m_axis_read_package.data = {len, sess};
    m_axis_read_package.keep = '1;
    m_axis_read_package.last = 1'b1;
    s_axis_rx_metadata.ready = state == META;
    m_axis_msg_meta.valid = state == MOUT;
    m_axis_msg_meta.data = {len, sess};
    m_axis_msg_meta.keep = '1;
    m_axis_msg_meta.last = 1'b1;
    s_axis_rx_data.ready = (state == DATA) & m_axis_msg_data.ready;
    m_axis_msg_data.valid = (state == DATA) & s_axis_rx_data.valid;
    m_axis_msg_data.data = s_axis_rx_data.data;
    m_axis_msg_data.keep = s_axis_rx_data.keep;
    m_axis_msg_data.last = s_axis_rx_data.last;
  end
  // byte count contributed by the current beat
  always_comb begin
    pop = '0;
    for (int i = 0; i < 8; i++) pop = pop + {3'b0, s_axis_rx_data.keep[i]};
  end
  // request latch, counters, sticky error flags and message counter
  always_ff @(posedge net_clk or posedge net_areset) begin
    if (net_areset) begin
      sess <= '0;
      len <= '0;
      tcnt <= '0;
      bcnt <= '0;
      err_len <= 1'b0;
      err_session <= 1'b0;
      err_timeout <= 1'b0;
      msg_count <= '0;
    end else begin
      if (n_acc) begin
        sess <= s_axis_notifications.data[15:0];
        len <= s_axis_notifications.data[31:16];
      end
      tcnt <= state == META ? tcnt + 16'd1 : '0;
      bcnt <= state != DATA ? '0 : (beat ? bcnt + {13'b0, pop} : bcnt);
      if (m_acc && s_axis_rx_metadata.data != sess) err_session <= 1'b1;
      if (state == META && !m_acc && tmo) err_timeout <= 1'b1;
      if (beat && s_axis_rx_data.last) begin
        msg_count <= msg_count + 32'd1;
        if (bcnt + {13'b0, pop} != {1'b0, len}) err_len <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tcp_rx_fetch.sv
// tb_tcp_rx_fetch: directed scoreboard bench for tcp_rx_fetch
module tb_tcp_rx_fetch;
  logic clk = 1'b0;
  logic rst;
  logic err_len, err_session, err_timeout;
  logic [31:0] msg_count;
  int checks = 0;
  int errors = 0;
  logic [31:0] rp_q[$];
  logic [31:0] mm_q[$];
  logic [72:0] bt_q[$];
  logic [31:0] e32;
  logic [72:0] e73;
  int k;
  bit found;

  always #5 clk = ~clk;

  tcp_rx_fetch_if #(.DW(88)) notif();
  tcp_rx_fetch_if #(.DW(32)) rp();
  tcp_rx_fetch_if #(.DW(16)) md();
  tcp_rx_fetch_if #(.DW(64)) rx();
  tcp_rx_fetch_if #(.DW(32)) mm();
  tcp_rx_fetch_if #(.DW(64)) mmd();

  tcp_rx_fetch #(.TIMEOUT_CYCLES(16)) dut (
    .net_clk(clk),
    .net_areset(rst),
    .s_axis_notifications(notif),
    .m_axis_read_package(rp),
    .s_axis_rx_metadata(md),
    .s_axis_rx_data(rx),
    .m_axis_msg_meta(mm),
    .m_axis_msg_data(mmd),
    .err_len(err_len),
    .err_session(err_session),
    .err_timeout(err_timeout),
    .msg_count(msg_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_notif(input logic [15:0] s, input logic [15:0] l, input logic cl, input bit exp_meta);
    bit ok = 0;
    if (l != 16'd0) begin
      rp_q.push_back({l, s});
      if (exp_meta) mm_q.push_back({l, s});
    end
    notif.data = '0;
    notif.data[15:0] = s;
    notif.data[31:16] = l;
    notif.data[63:32] = 32'hC0A8_0001;
    notif.data[79:64] = 16'd5001;
    notif.data[80] = cl;
    notif.valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (notif.ready) begin ok = 1; break; end
    end
    tick();
    notif.valid = 1'b0;
    if (!ok) chk("notif_wait", 0, 1);
  endtask

  task automatic send_meta(input logic [15:0] s);
    bit ok = 0;
    md.data = s;
    md.valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (md.ready) begin ok = 1; break; end
    end
    tick();
    md.valid = 1'b0;
    if (!ok) chk("meta_wait", 0, 1);
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] kp, input logic l);
    bt_q.push_back({d, kp, l});
    rx.data = d;
    rx.keep = kp;
    rx.last = l;
    rx.valid = 1'b1;
  endtask

  task automatic wait_beat();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rx.ready) begin ok = 1; break; end
    end
    tick();
    rx.valid = 1'b0;
    rx.last = 1'b0;
    if (!ok) chk("beat_wait", 0, 1);
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] kp, input logic l);
    drive_beat(d, kp, l);
    wait_beat();
  endtask

  // scoreboard: every output handshake is matched against the queued expectation
  always @(negedge clk) begin
    if (rp.valid && rp.ready) begin
      if (rp_q.size() == 0) chk("rp_extra", 1, 0);
      else begin e32 = rp_q.pop_front(); chk("rp_data", 64'(rp.data), 64'(e32)); end
    end
    if (mm.valid && mm.ready) begin
      if (mm_q.size() == 0) chk("meta_extra", 1, 0);
      else begin e32 = mm_q.pop_front(); chk("msg_meta", 64'(mm.data), 64'(e32)); end
    end
    if (mmd.valid && mmd.ready) begin
      if (bt_q.size() == 0) chk("beat_extra", 1, 0);
      else begin
        e73 = bt_q.pop_front();
        chk("beat_data", mmd.data, e73[72:9]);
        chk("beat_keep", 64'(mmd.keep), 64'(e73[8:1]));
        chk("beat_last", 64'(mmd.last), 64'(e73[0]));
      end
    end
  end

  initial begin
    rst = 1'b1;
    notif.valid = 1'b0; notif.data = '0; notif.keep = '0; notif.last = 1'b0;
    md.valid = 1'b0; md.data = '0; md.keep = '0; md.last = 1'b0;
    rx.valid = 1'b0; rx.data = '0; rx.keep = '0; rx.last = 1'b0;
    rp.ready = 1'b1; mm.ready = 1'b1; mmd.ready = 1'b1;
    tick(); tick();
    chk("rst_rp_valid", 64'(rp.valid), 0);
    chk("rst_rp_data", 64'(rp.data), 0);
    chk("rst_mm_valid", 64'(mm.valid), 0);
    chk("rst_mm_data", 64'(mm.data), 0);
    chk("rst_mmd_valid", 64'(mmd.valid), 0);
    chk("rst_flags", 64'({err_len, err_session, err_timeout}), 0);
    chk("rst_msg_count", 64'(msg_count), 0);
    rst = 1'b0;
    tick();
    chk("idle_notif_ready", 64'(notif.ready), 1);

    send_notif(16'h0055, 16'd0, 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      chk("len0_no_req", 64'(rp.valid), 0);
      chk("len0_idle", 64'(notif.ready), 1);
      tick();
    end
    chk("len0_count", 64'(msg_count), 0);

    send_notif(16'h0012, 16'd20, 1'b0, 1);
    chk("rp_valid_n1", 64'(rp.valid), 1);
    chk("rp_data_n1", 64'(rp.data), 64'h0014_0012);
    send_meta(16'h0012);
    send_beat(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
    send_beat(64'hFEDC_BA98_7654_3210, 8'hFF, 1'b0);
    send_beat(64'h0000_0000_A5A5_5A5A, 8'h0F, 1'b1);
    chk("m1_count", 64'(msg_count), 1);
    chk("m1_flags", 64'({err_len, err_session, err_timeout}), 0);
    chk("m1_idle", 64'(notif.ready), 1);

    send_notif(16'h0012, 16'd8, 1'b0, 1);
    send_meta(16'h0013);
    chk("sess_err", 64'(err_session), 1);
    send_beat(64'h1111_2222_3333_4444, 8'hFF, 1'b1);
    chk("sess_count", 64'(msg_count), 2);
    chk("sess_no_len_err", 64'(err_len), 0);

    send_notif(16'h0021, 16'd8, 1'b0, 0);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (md.ready) begin found = 1; break; end
      tick();
    end
    chk("meta_entry", 64'(found), 1);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (err_timeout) begin k = i; break; end
    end
    chk("timeout_cycles", 64'(k), 16);
    chk("timeout_idle", 64'(notif.ready), 1);
    chk("timeout_meta_ready", 64'(md.ready), 0);

    send_notif(16'h0030, 16'd16, 1'b0, 1);
    send_meta(16'h0030);
    mmd.ready = 1'b0;
    drive_beat(64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_rx_ready", 64'(rx.ready), 0);
    end
    mmd.ready = 1'b1;
    wait_beat();
    chk("len_err", 64'(err_len), 1);
    chk("len_count", 64'(msg_count), 3);

    send_notif(16'h0040, 16'd8, 1'b0, 1);
    send_meta(16'h0040);
    tick(); tick();
    rst = 1'b1;
    rx.data = 64'h5555_AAAA_5555_AAAA;
    rx.keep = 8'hFF;
    rx.valid = 1'b1;
    #1;
    chk("arst_rp_valid", 64'(rp.valid), 0);
    chk("arst_mm_valid", 64'(mm.valid), 0);
    chk("arst_mmd_valid", 64'(mmd.valid), 0);
    chk("arst_rx_ready", 64'(rx.ready), 0);
    chk("arst_flags", 64'({err_len, err_session, err_timeout}), 0);
    chk("arst_count", 64'(msg_count), 0);
    rx.valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    send_notif(16'h0012, 16'd20, 1'b0, 1);
    send_meta(16'h0012);
    send_beat(64'h0F0E_0D0C_0B0A_0908, 8'hFF, 1'b0);
    send_beat(64'h0706_0504_0302_0100, 8'hFF, 1'b0);
    send_beat(64'h0000_0000_1357_9BDF, 8'h0F, 1'b1);
    chk("post_count", 64'(msg_count), 1);
    chk("post_flags", 64'({err_len, err_session, err_timeout}), 0);
    tick();
    chk("rp_q_empty", 64'(rp_q.size()), 0);
    chk("mm_q_empty", 64'(mm_q.size()), 0);
    chk("bt_q_empty", 64'(bt_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
